// File: rtl/parity_pkg.sv
// Shared definitions for the odd-parity serial link (checker and generator sides).
package parity_pkg;

    localparam int DATA_W     = 3;
    localparam int FRAME_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Codeword {A, P} is good when it carries an odd number of ones.
    function automatic logic odd_parity_err(input logic [FRAME_BITS-1:0] codeword);
        return ~(^codeword);
    endfunction

endpackage

// File: rtl/odd_parity_check.sv
// Combinational odd-parity checker over the received 4-bit codeword {A, P}.
module odd_parity_check
    import parity_pkg::*;
(
    input  logic [FRAME_BITS-1:0] codeword_i,
    output logic                  err_o
);

    // Flag an even ones count as a parity error.
    always_comb begin
        err_o = odd_parity_err(codeword_i);
    end

endmodule

// File: rtl/odd_parity_serial_checker.sv
// Serial receiver for start + A[2:0] + P + stop frames; presents data with parity/frame status.
module odd_parity_serial_checker
    import parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              out_valid,
    output logic              overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    logic                  sync1_q, sync2_q, prev_q;
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  rx_s, fall_s, done_s, accept_s, perr_s;

    assign rx_s     = sync2_q;
    assign fall_s   = prev_q & ~sync2_q;
    assign accept_s = valid_q & out_ready;

    odd_parity_check u_parity (
        .codeword_i (shift_q),
        .err_o      (perr_s)
    );

    // Receive FSM: START sample re-aligns the counter so DATA/STOP sample mid-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_cnt_d = 2'd0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[FRAME_BITS-2:0], rx_s};
                    if (bit_cnt_q == 2'd3) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Result hand-off: a frame finishing while the old result is still unaccepted is dropped.
    always_comb begin
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (done_s) begin
            if (!valid_q || accept_s) begin
                data_d  = shift_q[FRAME_BITS-1:1];
                perr_d  = perr_s;
                ferr_d  = ~rx_s;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 2'd0;
            shift_q   <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign out_valid  = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_odd_parity_serial_checker.sv
// Directed self-checking bench for odd_parity_serial_checker at CLKS_PER_BIT=4.
module tb_odd_parity_serial_checker;
    import parity_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       out_ready = 1'b0;
    logic [2:0] data_out;
    logic       parity_err, frame_err, out_valid, overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int ovr_cycles = 0;
    int valid_rises = 0;
    logic valid_prev = 1'b0;
    int base;

    odd_parity_serial_checker #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .out_valid  (out_valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (overrun) ovr_cycles++;
        if (out_valid && !valid_prev) valid_rises++;
        valid_prev = out_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [2:0] a, input logic p, input logic stop);
        drive_bit(1'b0);
        drive_bit(a[2]);
        drive_bit(a[1]);
        drive_bit(a[0]);
        drive_bit(p);
        drive_bit(stop);
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("valid_drop_after_accept", 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid",   32'(out_valid),   32'd0);
        check_eq("rst_data",    32'(data_out),    32'd0);
        check_eq("rst_perr",    32'(parity_err),  32'd0);
        check_eq("rst_ferr",    32'(frame_err),   32'd0);
        check_eq("rst_overrun", 32'(overrun),     32'd0);
        check_eq("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // A=101 P=1: good frame
        send_frame(3'b101, 1'b1, 1'b1);
        check_eq("f1_valid", 32'(out_valid),  32'd1);
        check_eq("f1_data",  32'(data_out),   32'h5);
        check_eq("f1_perr",  32'(parity_err), 32'd0);
        check_eq("f1_ferr",  32'(frame_err),  32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("f1_hold_valid", 32'(out_valid), 32'd1);
        check_eq("f1_hold_data",  32'(data_out),  32'h5);
        consume();

        // A=100 P=1: even ones -> parity error
        send_frame(3'b100, 1'b1, 1'b1);
        check_eq("f2_data", 32'(data_out),   32'h4);
        check_eq("f2_perr", 32'(parity_err), 32'd1);
        check_eq("f2_ferr", 32'(frame_err),  32'd0);
        consume();

        // A=011 P=1 with stop bit 0: frame error
        send_frame(3'b011, 1'b1, 1'b0);
        check_eq("f3_valid", 32'(out_valid),  32'd1);
        check_eq("f3_data",  32'(data_out),   32'h3);
        check_eq("f3_perr",  32'(parity_err), 32'd0);
        check_eq("f3_ferr",  32'(frame_err),  32'd1);
        consume();
        repeat (4) @(posedge clk);
        #1;
        send_frame(3'b010, 1'b0, 1'b1);
        check_eq("f4_data", 32'(data_out),   32'h2);
        check_eq("f4_perr", 32'(parity_err), 32'd0);
        check_eq("f4_ferr", 32'(frame_err),  32'd0);
        consume();

        // One-cycle low glitch on idle line
        base = valid_rises;
        repeat (4) @(posedge clk);
        #1;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("glitch_no_result", 32'(valid_rises - base), 32'd0);
        check_eq("glitch_valid",     32'(out_valid),          32'd0);
        check_eq("glitch_state",     32'(dut.state_q),        32'(ST_IDLE));

        // Overrun: two frames with out_ready low
        ovr_cycles = 0;
        send_frame(3'b101, 1'b1, 1'b1);
        check_eq("ovr_first_valid", 32'(out_valid), 32'd1);
        check_eq("ovr_no_pulse_yet", 32'(ovr_cycles), 32'd0);
        send_frame(3'b000, 1'b1, 1'b1);
        check_eq("ovr_pulse_once", 32'(ovr_cycles), 32'd1);
        check_eq("ovr_data_held",  32'(data_out),   32'h5);
        check_eq("ovr_perr_held",  32'(parity_err), 32'd0);
        check_eq("ovr_valid_held", 32'(out_valid),  32'd1);
        consume();

        // Reset mid-frame while a result is held
        send_frame(3'b111, 1'b0, 1'b1);
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_valid", 32'(out_valid),   32'd0);
        check_eq("midrst_data",  32'(data_out),    32'd0);
        check_eq("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        base = valid_rises;
        send_frame(3'b110, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_eq("postrst_one_result", 32'(valid_rises - base), 32'd1);
        check_eq("postrst_data",       32'(data_out),           32'h6);
        check_eq("postrst_perr",       32'(parity_err),         32'd0);
        check_eq("postrst_ferr",       32'(frame_err),          32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
